// File: rtl/logcap_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : logcap_cmd_responder
// Description : Command-side responder for LogicCaptureTop. Decodes hub
//               function codes, latches buffer/trigger configuration, pulses
//               capture-engine controls, serves trace size/data/trigger
//               sample on regOut0..7 and drives the status/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module logcap_cmd_responder #(
    parameter int TRACE_AW   = 16,
    parameter int RD_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [7:0]          command,
    input  logic                commandStrobe,
    input  logic [7:0]          regIn0,
    input  logic [7:0]          regIn1,
    input  logic [7:0]          regIn2,
    input  logic [7:0]          regIn3,
    input  logic [7:0]          regIn4,
    input  logic [7:0]          regIn5,
    input  logic [7:0]          regIn6,
    input  logic [7:0]          regIn7,
    output logic [7:0]          regOut0,
    output logic [7:0]          regOut1,
    output logic [7:0]          regOut2,
    output logic [7:0]          regOut3,
    output logic [7:0]          regOut4,
    output logic [7:0]          regOut5,
    output logic [7:0]          regOut6,
    output logic [7:0]          regOut7,
    output logic [7:0]          status,
    input  logic                cap_idle,
    input  logic                cap_running,
    input  logic                cap_triggered,
    output logic                cap_start,
    output logic                cap_abort,
    output logic                cap_reset,
    output logic [31:0]         cfg_pre_count,
    output logic [31:0]         cfg_total_count,
    output logic [15:0]         cfg_pattern,
    output logic [15:0]         cfg_active,
    output logic [15:0]         cfg_dontcare,
    output logic [7:0]          cfg_edge_chan,
    output logic                cfg_edge_pos,
    output logic                cfg_edge_en,
    output logic                cfg_pat_en,
    input  logic [31:0]         trace_bytes,
    input  logic [15:0]         trig_sample,
    output logic                rd_en,
    output logic [TRACE_AW-1:0] rd_addr,
    input  logic [63:0]         rd_data,
    input  logic                rd_valid
);

    localparam logic [7:0] c_NOP      = 8'h00;
    localparam logic [7:0] c_START    = 8'h01;
    localparam logic [7:0] c_ABORT    = 8'h02;
    localparam logic [7:0] c_TRIG_CFG = 8'h03;
    localparam logic [7:0] c_BUF_CFG  = 8'h04;
    localparam logic [7:0] c_RD_DATA  = 8'h05;
    localparam logic [7:0] c_RD_SIZE  = 8'h06;
    localparam logic [7:0] c_RD_TRIG  = 8'h07;
    localparam logic [7:0] c_ACK      = 8'h08;
    localparam logic [7:0] c_RESET    = 8'h09;

    localparam logic [31:0] c_TOTAL_RST  = 32'd8;
    localparam logic [15:0] c_ACTIVE_RST = 16'hFFFF;

    // Timeout counter only has to reach RD_TIMEOUT-1
    localparam int c_TMO_W = $clog2(RD_TIMEOUT + 1);
    // Byte-offset comparison width: wide enough for both rd_ptr*8 and trace_bytes
    localparam int c_CW = (TRACE_AW + 3 > 32) ? TRACE_AW + 3 : 32;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_RD_WAIT  = 2'd2,
        S_ACK_WAIT = 2'd3
    } state_t;

    state_t              r_state;
    logic [7:0]          r_cmd;
    logic [TRACE_AW-1:0] r_rdPtr;
    logic [63:0]         r_regOut;
    logic                r_ack;
    logic                r_err;
    logic [c_TMO_W-1:0]  r_tmoCnt;

    logic [31:0]   w_pre;
    logic [31:0]   w_total;
    logic          w_cfgBad;
    logic [c_CW-1:0] w_ptrBytes;
    logic          w_rdEnd;

    assign w_pre      = {regIn7, regIn6, regIn5, regIn4};
    assign w_total    = {regIn3, regIn2, regIn1, regIn0};
    assign w_cfgBad   = (w_pre > w_total) || (w_total == 32'd0);
    // Reading past the captured data is an error rather than a bus access
    assign w_ptrBytes = c_CW'({r_rdPtr, 3'b000});
    assign w_rdEnd    = w_ptrBytes >= c_CW'(trace_bytes);

    assign status  = {3'b000, r_err, r_ack, cap_triggered, cap_running, cap_idle};
    assign regOut0 = r_regOut[7:0];
    assign regOut1 = r_regOut[15:8];
    assign regOut2 = r_regOut[23:16];
    assign regOut3 = r_regOut[31:24];
    assign regOut4 = r_regOut[39:32];
    assign regOut5 = r_regOut[47:40];
    assign regOut6 = r_regOut[55:48];
    assign regOut7 = r_regOut[63:56];

    // Command FSM: decode, execute, wait for trace data, hold ack until host ACK
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state         <= S_IDLE;
            r_cmd           <= c_NOP;
            r_rdPtr         <= '0;
            r_regOut        <= '0;
            r_ack           <= 1'b0;
            r_err           <= 1'b0;
            r_tmoCnt        <= '0;
            cap_start       <= 1'b0;
            cap_abort       <= 1'b0;
            cap_reset       <= 1'b0;
            rd_en           <= 1'b0;
            rd_addr         <= '0;
            cfg_pre_count   <= 32'd0;
            cfg_total_count <= c_TOTAL_RST;
            cfg_pattern     <= 16'd0;
            cfg_active      <= c_ACTIVE_RST;
            cfg_dontcare    <= 16'd0;
            cfg_edge_chan   <= 8'd0;
            cfg_edge_pos    <= 1'b0;
            cfg_edge_en     <= 1'b0;
            cfg_pat_en      <= 1'b0;
        end else begin
            cap_start <= 1'b0;
            cap_abort <= 1'b0;
            cap_reset <= 1'b0;
            rd_en     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // NOP and a stray ACK are swallowed without a response
                    if (commandStrobe && command != c_NOP && command != c_ACK) begin
                        r_cmd   <= command;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_ack   <= 1'b1;
                    r_state <= S_ACK_WAIT;
                    case (r_cmd)
                        c_START: begin
                            r_rdPtr <= '0;
                            if (cap_idle) cap_start <= 1'b1;
                            else          r_err     <= 1'b1;
                        end
                        c_ABORT: cap_abort <= 1'b1;
                        c_BUF_CFG: begin
                            if (w_cfgBad) begin
                                r_err <= 1'b1;
                            end else begin
                                cfg_pre_count   <= w_pre;
                                cfg_total_count <= w_total;
                            end
                        end
                        c_TRIG_CFG: begin
                            cfg_pattern   <= {regIn1, regIn0};
                            cfg_active    <= {regIn3, regIn2};
                            cfg_dontcare  <= {regIn5, regIn4};
                            cfg_edge_chan <= regIn6;
                            {cfg_edge_pos, cfg_edge_en, cfg_pat_en} <= regIn7[2:0];
                        end
                        c_RD_SIZE: begin
                            r_regOut <= {32'd0, trace_bytes};
                            r_rdPtr  <= '0;
                        end
                        c_RD_TRIG: r_regOut <= {48'd0, trig_sample};
                        c_RD_DATA: begin
                            if (w_rdEnd) begin
                                r_regOut <= '0;
                                r_err    <= 1'b1;
                            end else begin
                                // Ack is deferred until the trace word arrives
                                rd_en    <= 1'b1;
                                rd_addr  <= r_rdPtr;
                                r_ack    <= 1'b0;
                                r_tmoCnt <= '0;
                                r_state  <= S_RD_WAIT;
                            end
                        end
                        c_RESET: begin
                            cap_reset       <= 1'b1;
                            r_rdPtr         <= '0;
                            cfg_pre_count   <= 32'd0;
                            cfg_total_count <= c_TOTAL_RST;
                            cfg_pattern     <= 16'd0;
                            cfg_active      <= c_ACTIVE_RST;
                            cfg_dontcare    <= 16'd0;
                            cfg_edge_chan   <= 8'd0;
                            cfg_edge_pos    <= 1'b0;
                            cfg_edge_en     <= 1'b0;
                            cfg_pat_en      <= 1'b0;
                        end
                        default: r_err <= 1'b1;
                    endcase
                end
                S_RD_WAIT: begin
                    if (rd_valid) begin
                        r_regOut <= rd_data;
                        r_rdPtr  <= r_rdPtr + TRACE_AW'(1);
                        r_ack    <= 1'b1;
                        r_state  <= S_ACK_WAIT;
                    end else if (r_tmoCnt == c_TMO_W'(RD_TIMEOUT - 1)) begin
                        // Give up: report error, leave regOut as it was
                        r_err   <= 1'b1;
                        r_ack   <= 1'b1;
                        r_state <= S_ACK_WAIT;
                    end else begin
                        r_tmoCnt <= r_tmoCnt + c_TMO_W'(1);
                    end
                end
                S_ACK_WAIT: begin
                    if (commandStrobe && command == c_ACK) begin
                        r_ack   <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logcap_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_logcap_cmd_responder
// Description : Scoreboard bench for logcap_cmd_responder. A behavioural
//               model predicts each response; a monitor pops and compares
//               whenever the DUT raises ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logcap_cmd_responder;

    localparam int AW  = 16;
    localparam int TMO = 16;

    localparam logic [7:0] NOP = 8'h00, START = 8'h01, ABORT = 8'h02, TRIG_CFG = 8'h03,
                           BUF_CFG = 8'h04, RD_DATA = 8'h05, RD_SIZE = 8'h06,
                           RD_TRIG = 8'h07, ACK = 8'h08, RESET = 8'h09;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  command = 8'h00;
    logic        commandStrobe = 1'b0;
    logic [7:0]  regIn [8];
    logic [7:0]  regOut0, regOut1, regOut2, regOut3, regOut4, regOut5, regOut6, regOut7;
    logic [7:0]  status;
    logic        cap_idle = 1'b1, cap_running = 1'b0, cap_triggered = 1'b0;
    logic        cap_start, cap_abort, cap_reset;
    logic [31:0] cfg_pre_count, cfg_total_count;
    logic [15:0] cfg_pattern, cfg_active, cfg_dontcare;
    logic [7:0]  cfg_edge_chan;
    logic        cfg_edge_pos, cfg_edge_en, cfg_pat_en;
    logic [31:0] trace_bytes = 32'd0;
    logic [15:0] trig_sample = 16'd0;
    logic        rd_en;
    logic [AW-1:0] rd_addr;
    logic [63:0] rd_data = 64'd0;
    logic        rd_valid = 1'b0;

    logcap_cmd_responder #(.TRACE_AW(AW), .RD_TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn), .command(command), .commandStrobe(commandStrobe),
        .regIn0(regIn[0]), .regIn1(regIn[1]), .regIn2(regIn[2]), .regIn3(regIn[3]),
        .regIn4(regIn[4]), .regIn5(regIn[5]), .regIn6(regIn[6]), .regIn7(regIn[7]),
        .regOut0(regOut0), .regOut1(regOut1), .regOut2(regOut2), .regOut3(regOut3),
        .regOut4(regOut4), .regOut5(regOut5), .regOut6(regOut6), .regOut7(regOut7),
        .status(status), .cap_idle(cap_idle), .cap_running(cap_running),
        .cap_triggered(cap_triggered), .cap_start(cap_start), .cap_abort(cap_abort),
        .cap_reset(cap_reset), .cfg_pre_count(cfg_pre_count), .cfg_total_count(cfg_total_count),
        .cfg_pattern(cfg_pattern), .cfg_active(cfg_active), .cfg_dontcare(cfg_dontcare),
        .cfg_edge_chan(cfg_edge_chan), .cfg_edge_pos(cfg_edge_pos), .cfg_edge_en(cfg_edge_en),
        .cfg_pat_en(cfg_pat_en), .trace_bytes(trace_bytes), .trig_sample(trig_sample),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    wire [63:0]  ro = {regOut7, regOut6, regOut5, regOut4, regOut3, regOut2, regOut1, regOut0};
    wire [122:0] dutCfg = {cfg_pre_count, cfg_total_count, cfg_pattern, cfg_active,
                           cfg_dontcare, cfg_edge_chan, cfg_edge_pos, cfg_edge_en, cfg_pat_en};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] ro;
        logic        err;
    } resp_t;
    resp_t sbq[$];

    // Behavioural model state
    logic [31:0] mPre, mTotal;
    logic [15:0] mPat, mAct, mDc;
    logic [7:0]  mChan;
    logic [2:0]  mFlg;
    int unsigned mPtr;
    logic [63:0] mRo;

    // Trace memory model controls
    bit memOn = 1'b1;
    bit mixData = 1'b0;
    int minDly = 0, maxDly = 3;
    bit pend = 1'b0;
    int dly = 0;
    logic [AW-1:0] pAddr = '0;

    int startCnt = 0, abortCnt = 0, rstCnt = 0;
    logic prevAck = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] tw(input logic [AW-1:0] a);
        if (mixData) return {a ^ 16'hA5C3, 16'(a * 7), a ^ 16'hBEEF, a};
        return 64'(a);
    endfunction

    function automatic void modelReset();
        mPre = 32'd0; mTotal = 32'd8; mPat = 16'd0; mAct = 16'hFFFF; mDc = 16'd0;
        mChan = 8'd0; mFlg = 3'd0; mPtr = 0;
    endfunction

    function automatic logic [122:0] modelCfg();
        return {mPre, mTotal, mPat, mAct, mDc, mChan, mFlg};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Trace memory: answers rd_en with word data after a random delay
    always @(negedge clk) begin
        rd_valid <= 1'b0;
        if (pend) begin
            if (dly == 0) begin
                rd_valid <= memOn;
                rd_data  <= tw(pAddr);
                pend     <= 1'b0;
            end else begin
                dly <= dly - 1;
            end
        end else if (rd_en === 1'b1) begin
            pend  <= 1'b1;
            dly   <= int'($urandom_range(maxDly, minDly));
            pAddr <= rd_addr;
        end
    end

    // Monitor: pulse counters and scoreboard pop on every rising ack
    always @(negedge clk) begin
        resp_t r;
        if (cap_start === 1'b1) startCnt <= startCnt + 1;
        if (cap_abort === 1'b1) abortCnt <= abortCnt + 1;
        if (cap_reset === 1'b1) rstCnt   <= rstCnt + 1;
        prevAck <= status[3];
        if (status[3] === 1'b1 && prevAck !== 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected ack", 1, 0);
            end else begin
                r = sbq.pop_front();
                chk("regOut", ro, r.ro);
                chk("err", status[4], r.err);
            end
        end
    end

    task automatic strobe(input logic [7:0] c);
        @(posedge clk); #1;
        command = c;
        commandStrobe = 1'b1;
        @(posedge clk); #1;
        commandStrobe = 1'b0;
        command = 8'($urandom);
    endtask

    task automatic waitAck(output int n, input int budget);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (status[3] === 1'b1) break;
            if (n >= budget) begin
                chk("ack wait timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic waitRdEn(output int c0);
        int n = 0;
        c0 = 0;
        forever begin
            @(negedge clk);
            n++;
            if (rd_en === 1'b1) begin
                c0 = cyc;
                break;
            end
            if (n >= 10) begin
                chk("rd_en wait timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic sendAck();
        strobe(ACK);
        @(negedge clk);
        chk("ack/err cleared", status[4:3], 2'b00);
    endtask

    task automatic checkReset();
        modelReset();
        chk("reset regOut", ro, 0);
        chk("reset ack/err", status[4:3], 2'b00);
        chk("reset pulses", {cap_start, cap_abort, cap_reset, rd_en}, 4'b0000);
        chk("reset rd_addr", rd_addr, 0);
        chk("reset cfg", dutCfg, modelCfg());
        chk("status mirror", status, {5'b00000, cap_triggered, cap_running, cap_idle});
    endtask

    // Predict the response from the command rules, issue it and wait for ack
    task automatic issue(input logic [7:0] code, output bit acked);
        bit expErr = 1'b0, quick = 1'b1;
        int n, s0, a0, r0;
        int expS = 0, expA = 0, expR = 0;
        logic [31:0] pre, tot;
        acked = 1'b1;
        pre = {regIn[7], regIn[6], regIn[5], regIn[4]};
        tot = {regIn[3], regIn[2], regIn[1], regIn[0]};
        case (code)
            NOP, ACK: acked = 1'b0;
            START: begin expErr = !cap_idle; expS = cap_idle ? 1 : 0; mPtr = 0; end
            ABORT: expA = 1;
            BUF_CFG: begin
                if (pre > tot || tot == 0) expErr = 1'b1;
                else begin mPre = pre; mTotal = tot; end
            end
            TRIG_CFG: begin
                mPat = {regIn[1], regIn[0]}; mAct = {regIn[3], regIn[2]};
                mDc = {regIn[5], regIn[4]}; mChan = regIn[6]; mFlg = regIn[7][2:0];
            end
            RD_SIZE: begin mRo = {32'd0, trace_bytes}; mPtr = 0; end
            RD_TRIG: mRo = {48'd0, trig_sample};
            RD_DATA: begin
                if (longint'(mPtr) * 8 >= longint'(trace_bytes)) begin
                    mRo = 64'd0; expErr = 1'b1;
                end else begin
                    quick = 1'b0;
                    if (memOn) begin
                        mRo = tw(AW'(mPtr));
                        mPtr = (mPtr + 1) % (1 << AW);
                    end else begin
                        expErr = 1'b1;
                    end
                end
            end
            RESET: begin modelReset(); expR = 1; end
            default: expErr = 1'b1;
        endcase
        if (acked) sbq.push_back('{ro: mRo, err: expErr});
        s0 = startCnt; a0 = abortCnt; r0 = rstCnt;
        strobe(code);
        if (!acked) begin
            repeat (3) @(negedge clk);
            chk("ignored code no ack", status[3], 1'b0);
            return;
        end
        waitAck(n, TMO + 20);
        if (quick) chk("ack latency", n, 2);
        chk("cfg", dutCfg, modelCfg());
        @(negedge clk);
        chk("pulse counts", {8'(startCnt - s0), 8'(abortCnt - a0), 8'(rstCnt - r0)},
            {8'(expS), 8'(expA), 8'(expR)});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acked;
        int c0, c1, n, s0;
        logic [31:0] pre, tot;
        for (int i = 0; i < 8; i++) regIn[i] = 8'h00;
        mRo = 64'd0;
        modelReset();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        checkReset();

        // Buffer config pre=20 total=110
        regIn[0] = 8'd110; regIn[4] = 8'd20;
        issue(BUF_CFG, acked); sendAck();

        // Trigger config
        regIn[0] = 8'h9D; regIn[1] = 8'hCC; regIn[2] = 8'hFF; regIn[3] = 8'hFF;
        regIn[4] = 8'h00; regIn[5] = 8'h00; regIn[6] = 8'h02; regIn[7] = 8'h07;
        issue(TRIG_CFG, acked); sendAck();

        // Full trace readout then one past the end
        trace_bytes = 32'd880;
        issue(RD_SIZE, acked); sendAck();
        for (int i = 0; i < 111; i++) begin
            issue(RD_DATA, acked); sendAck();
        end

        // START refused when not idle, accepted when idle
        cap_idle = 1'b0;
        issue(START, acked); sendAck();
        cap_idle = 1'b1;
        issue(START, acked); sendAck();

        // Non-ACK strobe while waiting for ACK is ignored
        trig_sample = 16'h5AC3;
        issue(RD_TRIG, acked);
        trace_bytes = 32'd64;
        strobe(RD_SIZE);
        repeat (3) @(negedge clk);
        chk("ackwait hold status", status[4:3], 2'b01);
        chk("ackwait hold regOut", ro, mRo);
        sendAck();

        // Read timeout, with a START strobe dropped during RD_WAIT
        memOn = 1'b0;
        sbq.push_back('{ro: mRo, err: 1'b1});
        s0 = startCnt;
        strobe(RD_DATA);
        waitRdEn(c0);
        strobe(START);
        waitAck(n, TMO + 20);
        c1 = cyc;
        chk("timeout latency", c1 - c0, TMO);
        @(negedge clk);
        chk("dropped START", startCnt - s0, 0);
        sendAck();
        memOn = 1'b1;

        // Reset during RD_WAIT; the late rd_valid must be ignored
        minDly = 3; maxDly = 3;
        strobe(RD_DATA);
        waitRdEn(c0);
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        mRo = 64'd0;
        @(negedge clk);
        checkReset();
        repeat (6) @(negedge clk);
        chk("late rd_valid ignored", {status[4:3], ro}, 66'd0);
        minDly = 0; maxDly = 3;

        // Randomized command mix
        mixData = 1'b1;
        for (int k = 0; k < 80; k++) begin
            logic [7:0] code;
            int sel;
            cap_idle = 1'($urandom);
            cap_running = 1'($urandom);
            cap_triggered = 1'($urandom);
            trace_bytes = 32'($urandom_range(12, 0)) * 32'd8;
            trig_sample = 16'($urandom);
            for (int i = 0; i < 8; i++) regIn[i] = 8'($urandom);
            sel = int'($urandom_range(11, 0));
            if (sel <= 9) code = 8'(sel);
            else if (sel == 10) code = 8'($urandom_range(255, 10));
            else code = RD_DATA;
            if (code == BUF_CFG) begin
                pre = 32'($urandom_range(60, 0));
                tot = 32'($urandom_range(60, 0));
                {regIn[7], regIn[6], regIn[5], regIn[4]} = pre;
                {regIn[3], regIn[2], regIn[1], regIn[0]} = tot;
            end
            #1;
            chk("status mirror", status[2:0], {cap_triggered, cap_running, cap_idle});
            issue(code, acked);
            if (acked) sendAck();
        end

        repeat (4) @(negedge clk);
        chk("scoreboard drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logcap_cmd_responder.md
Name: logcap_cmd_responder

Overview:
- Command-side responder inside LogicCaptureTop, answering the hub's command/strobe/ack protocol.
- Decodes 8-bit function codes, latches buffer and trigger configuration from regIn0..7, and pulses capture-engine controls.
- Serves trace size, trace data and trigger sample back on regOut0..7, and drives the status byte, including the ack handshake.

Parameters:
- TRACE_AW, 16, trace buffer word address width (one word = 64 bits = 8 bytes)
- RD_TIMEOUT, 64, clocks to wait for trace rd_valid before flagging an error

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- command  input  8  function code
- commandStrobe  input  1  one-cycle command qualifier
- regIn0..regIn7  input  8 each  host argument registers
- regOut0..regOut7  output  8 each  response registers
- status  output  8  [0] idle, [1] capturing, [2] triggered, [3] ack, [4] err, [7:5] 0
- cap_idle, cap_running, cap_triggered  input  1 each  capture engine state
- cap_start, cap_abort, cap_reset  output  1 each  one-cycle pulses
- cfg_pre_count, cfg_total_count  output  32 each  buffer configuration
- cfg_pattern, cfg_active, cfg_dontcare  output  16 each  pattern trigger configuration
- cfg_edge_chan  output  8  edge trigger channel
- cfg_edge_pos, cfg_edge_en, cfg_pat_en  output  1 each  trigger flags
- trace_bytes  input  32  bytes captured, always a multiple of 8
- trig_sample  input  16  sample at the trigger point
- rd_en  output  1  one-cycle trace read request
- rd_addr  output  TRACE_AW  word address
- rd_data  input  64  read data
- rd_valid  input  1  rd_data qualifier, arrives 1 or more cycles after rd_en

Behaviour:
- Codes:
  - NOP 00, START 01, ABORT 02, TRIG_CFG 03, BUF_CFG 04, RD_DATA 05, RD_SIZE 06, RD_TRIG 07, ACK 08, RESET 09.
- Reset values:
  - All outputs 0, except cfg_active=16'hFFFF and cfg_total_count=32'd8.
  - State IDLE, rd_ptr=0.
- status[2:0] is a combinational mirror of {cap_triggered, cap_running, cap_idle}. status[4:3] are registered.
- States are IDLE, EXEC, RD_WAIT and ACK_WAIT.
- IDLE: on strobe, latch command and go to EXEC. NOP is discarded and the state stays IDLE.
- EXEC (one cycle): perform the command, set ack=1, go to ACK_WAIT. Ack is therefore visible 2 clocks after the strobe edge. Per command:
  - START: pulse cap_start if cap_idle; otherwise no pulse and err=1. rd_ptr is cleared either way.
  - ABORT: pulse cap_abort.
  - BUF_CFG: pre={regIn7..4}, total={regIn3..0}. If pre>total or total==0, the configuration is not updated and err=1.
  - TRIG_CFG: pattern={regIn1,regIn0}, active={regIn3,regIn2}, dontcare={regIn5,regIn4}, edge_chan=regIn6, {edge_pos,edge_en,pat_en}=regIn7[2:0].
  - RD_SIZE: {regOut3..0}=trace_bytes, regOut7..4=0, rd_ptr=0.
  - RD_TRIG: {regOut1,regOut0}=trig_sample, others 0.
  - RD_DATA:
    - If rd_ptr*8 >= trace_bytes: regOut=0 and err=1.
    - Otherwise pulse rd_en with rd_addr=rd_ptr, do not set ack, and go to RD_WAIT.
  - RESET: pulse cap_reset, return config to reset values, rd_ptr=0.
  - ACK received in IDLE: ignored, no ack.
  - Undefined code: err=1.
- RD_WAIT:
  - On rd_valid: {regOut7..0}=rd_data (regOut0 is the LSB), rd_ptr+1, ack=1, go to ACK_WAIT.
  - After RD_TIMEOUT clocks without rd_valid: err=1, ack=1, regOut unchanged.
- ACK_WAIT:
  - Strobe with ACK: ack=0, err=0, go to IDLE. regOut holds its value.
  - Any other strobed code is ignored and ack stays 1.
- A strobe seen in EXEC or RD_WAIT is dropped.
- rd_ptr wraps modulo 2^TRACE_AW.
- Reset mid-transaction returns to IDLE at once with all outputs at reset values. A late rd_valid is then ignored.

Test Plan:
- BUF_CFG, regIn={20,110} (pre, total) -> cfg_pre_count=20, cfg_total_count=110, status[3] high 2 clocks after strobe, err=0. ACK strobe then clears ack by the next clock.
- TRIG_CFG, pattern 16'hCC9D, active FFFF, dontcare 0, chan 2, regIn7=3'b111 -> cfg fields match exactly.
- RD_SIZE with trace_bytes=880, then 110 RD_DATA/ACK pairs with a model returning word=addr -> regOut equals 0..109 in order. The 111th read gives err=1 and regOut=0.
- START while cap_idle=0 -> no cap_start pulse, err=1. START while idle -> cap_start high for exactly 1 cycle.
- rd_valid withheld on RD_DATA -> ack and err asserted RD_TIMEOUT clocks after rd_en.
- Non-ACK strobe in ACK_WAIT, strobe during RD_WAIT, and resetn low during RD_WAIT -> state unchanged for the first two cases. The reset case gives all outputs at reset values next clock.
